// File: rtl/sbox_sched_pkg.sv
// Shared definitions for the time-shared S-box scheduler: FSM state encoding,
// operand sizes and counter width.
package sbox_sched_pkg;

  localparam int unsigned KEY_BYTES = 4;
  localparam int unsigned ST_BYTES  = 16;
  localparam int unsigned KEY_W     = 8 * KEY_BYTES;
  localparam int unsigned ST_W      = 8 * ST_BYTES;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_KEY  = 3'd1,
    RUN_ST   = 3'd2,
    DONE_KEY = 3'd3,
    DONE_ST  = 3'd4
  } state_e;

endpackage

// File: rtl/sbox_sched_s_box.sv
// AES forward S-box, purely combinational byte lookup.
// Ports: in_byte  - byte to substitute
//        out_byte_c - substituted byte (combinational)
module sbox_sched_s_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte_c
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte_c = SBOX[in_byte];

endmodule

// File: rtl/sbox_sched.sv
// Time-shared S-box scheduler: one S-box serves key-expansion SubWord (4 bytes)
// and datapath SubBytes (16 bytes) requests, one byte per RUN cycle.
// Ports: clk, rst_n (sync, active-low)
//        key_in_*  / key_out_* - 32-bit SubWord request / result handshakes
//        st_in_*   / st_out_*  - 128-bit SubBytes request / result handshakes
//        busy                  - FSM is not IDLE
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int unsigned KEY_PRIORITY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  input  logic [31:0]  key_in_data,
  output logic         key_out_valid,
  input  logic         key_out_ready,
  output logic [31:0]  key_out_data,
  input  logic         st_in_valid,
  output logic         st_in_ready,
  input  logic [127:0] st_in_data,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  output logic [127:0] st_out_data,
  output logic         busy
);

  localparam bit KEY_WINS = (KEY_PRIORITY != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ST_W-1:0]    work_q, work_d;
  logic [KEY_W-1:0]   key_res_q, key_res_d;
  logic [ST_W-1:0]    st_res_q, st_res_d;
  logic               key_out_valid_q, key_out_valid_d;
  logic               st_out_valid_q, st_out_valid_d;
  logic               busy_q, busy_d;
  logic [7:0]         sbox_in;
  logic [7:0]         sbox_out;

  // Byte currently being substituted.
  assign sbox_in = work_q[{cnt_q, 3'b000} +: 8];

  sbox_sched_s_box u_s_box (
    .in_byte    (sbox_in),
    .out_byte_c (sbox_out)
  );

  // Next-state, datapath and ready logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    key_res_d    = key_res_q;
    st_res_d     = st_res_q;
    key_in_ready = 1'b0;
    st_in_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        key_in_ready = KEY_WINS ? 1'b1 : ~st_in_valid;
        st_in_ready  = KEY_WINS ? ~key_in_valid : 1'b1;
        if (key_in_valid && key_in_ready) begin
          work_d  = ST_W'(key_in_data);
          cnt_d   = '0;
          state_d = RUN_KEY;
        end else if (st_in_valid && st_in_ready) begin
          work_d  = st_in_data;
          cnt_d   = '0;
          state_d = RUN_ST;
        end
      end
      RUN_KEY: begin
        key_res_d[{cnt_q[1:0], 3'b000} +: 8] = sbox_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(KEY_BYTES - 1)) state_d = DONE_KEY;
      end
      RUN_ST: begin
        st_res_d[{cnt_q, 3'b000} +: 8] = sbox_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ST_BYTES - 1)) state_d = DONE_ST;
      end
      DONE_KEY: if (key_out_ready) state_d = IDLE;
      DONE_ST:  if (st_out_ready)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    key_out_valid_d = (state_d == DONE_KEY);
    st_out_valid_d  = (state_d == DONE_ST);
    busy_d          = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      work_q          <= '0;
      key_res_q       <= '0;
      st_res_q        <= '0;
      key_out_valid_q <= 1'b0;
      st_out_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      work_q          <= work_d;
      key_res_q       <= key_res_d;
      st_res_q        <= st_res_d;
      key_out_valid_q <= key_out_valid_d;
      st_out_valid_q  <= st_out_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign key_out_valid = key_out_valid_q;
  assign key_out_data  = key_res_q;
  assign st_out_valid  = st_out_valid_q;
  assign st_out_data   = st_res_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sbox_sched.sv
// Testbench for sbox_sched: two instances (KEY_PRIORITY 0 and 1) share inputs;
// a transaction-level model predicts readies, valids, busy and result data.
module tb_sbox_sched;

  localparam int KEY_LAT = 5;
  localparam int ST_LAT  = 17;

  logic         clk;
  logic         rst_n;
  logic         key_in_valid;
  logic [31:0]  key_in_data;
  logic         key_out_ready;
  logic         st_in_valid;
  logic [127:0] st_in_data;
  logic         st_out_ready;

  logic         kir  [2];
  logic         kov  [2];
  logic [31:0]  kod  [2];
  logic         sir  [2];
  logic         sov  [2];
  logic [127:0] sod  [2];
  logic         bsy  [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [7:0] sb_tab [256];

  // Model state per instance (index = KEY_PRIORITY): 0 idle, 1 key op, 2 state op.
  int           m_kind [2];
  int           m_age  [2];
  logic [31:0]  m_kres [2];
  logic [127:0] m_sres [2];

  sbox_sched #(.KEY_PRIORITY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .key_in_valid(key_in_valid), .key_in_ready(kir[1]), .key_in_data(key_in_data),
    .key_out_valid(kov[1]), .key_out_ready(key_out_ready), .key_out_data(kod[1]),
    .st_in_valid(st_in_valid), .st_in_ready(sir[1]), .st_in_data(st_in_data),
    .st_out_valid(sov[1]), .st_out_ready(st_out_ready), .st_out_data(sod[1]),
    .busy(bsy[1])
  );

  sbox_sched #(.KEY_PRIORITY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .key_in_valid(key_in_valid), .key_in_ready(kir[0]), .key_in_data(key_in_data),
    .key_out_valid(kov[0]), .key_out_ready(key_out_ready), .key_out_data(kod[0]),
    .st_in_valid(st_in_valid), .st_in_ready(sir[0]), .st_in_data(st_in_data),
    .st_out_valid(sov[0]), .st_out_ready(st_out_ready), .st_out_data(sod[0]),
    .busy(bsy[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply, AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox_def(input int x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb_tab[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] w);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb_tab[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic exp_kir(input int p);
    return (m_kind[p] == 0) && (p == 1 || !st_in_valid);
  endfunction

  function automatic logic exp_sir(input int p);
    return (m_kind[p] == 0) && (p == 0 || !key_in_valid);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: acceptance starts a countdown; result appears after the latency.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        m_kind[p] <= 0;
        m_age[p]  <= 0;
        m_kres[p] <= '0;
        m_sres[p] <= '0;
      end else if (m_kind[p] == 0) begin
        if (key_in_valid && exp_kir(p)) begin
          m_kind[p] <= 1;
          m_age[p]  <= 1;
          m_kres[p] <= subword(key_in_data);
        end else if (st_in_valid && exp_sir(p)) begin
          m_kind[p] <= 2;
          m_age[p]  <= 1;
          m_sres[p] <= subbytes(st_in_data);
        end
      end else if ((m_kind[p] == 1 && m_age[p] >= KEY_LAT && key_out_ready) ||
                   (m_kind[p] == 2 && m_age[p] >= ST_LAT && st_out_ready)) begin
        m_kind[p] <= 0;
      end else if (m_age[p] < 1000) begin
        m_age[p] <= m_age[p] + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("kp%0d key_in_ready", p), 128'(kir[p]), 128'(exp_kir(p)));
        chk($sformatf("kp%0d st_in_ready", p), 128'(sir[p]), 128'(exp_sir(p)));
        chk($sformatf("kp%0d busy", p), 128'(bsy[p]), 128'(m_kind[p] != 0));
        chk($sformatf("kp%0d key_out_valid", p), 128'(kov[p]),
            128'(m_kind[p] == 1 && m_age[p] >= KEY_LAT));
        chk($sformatf("kp%0d st_out_valid", p), 128'(sov[p]),
            128'(m_kind[p] == 2 && m_age[p] >= ST_LAT));
        if (!(m_kind[p] == 1 && m_age[p] < KEY_LAT))
          chk($sformatf("kp%0d key_out_data", p), 128'(kod[p]), 128'(m_kres[p]));
        if (!(m_kind[p] == 2 && m_age[p] < ST_LAT))
          chk($sformatf("kp%0d st_out_data", p), sod[p], m_sres[p]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bsy[0] || bsy[1]) && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (bsy[0] || bsy[1]) begin
      n_err++;
      $display("FAIL drain: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    logic [127:0] pat;
    rst_n = 1'b0; key_in_valid = 1'b0; key_in_data = '0; key_out_ready = 1'b1;
    st_in_valid = 1'b0; st_in_data = '0; st_out_ready = 1'b1;
    for (int x = 0; x < 256; x++) sb_tab[x] = sbox_def(x);

    // Model pinned to hand-computed values.
    chk("model subword 03020100", 128'(subword(32'h03020100)), 128'h7B777C63);
    chk("model subword ffffffff", 128'(subword(32'hFFFFFFFF)), 128'h16161616);
    chk("model subbytes 0f..00", subbytes(128'h0F0E0D0C0B0A09080706050403020100),
        128'h76ABD7FE2B670130C56F6BF27B777C63);

    tick();
    chk_en = 1'b1;
    tick();
    chk("reset busy", 128'(bsy[1]), 128'd0);
    chk("reset key_out_data", 128'(kod[1]), 128'd0);
    chk("reset st_out_data", sod[0], 128'd0);
    rst_n = 1'b1;
    tick();

    // Single key request: valid at T+5, busy T+1..T+5.
    key_in_data = 32'h03020100; key_in_valid = 1'b1;
    tick();
    key_in_valid = 1'b0;
    chk("key T+1 busy", 128'(bsy[1]), 128'd1);
    repeat (3) tick();
    chk("key T+4 valid", 128'(kov[1]), 128'd0);
    tick();
    chk("key T+5 valid", 128'(kov[1]), 128'd1);
    chk("key T+5 data", 128'(kod[1]), 128'h7B777C63);
    chk("key T+5 busy", 128'(bsy[0]), 128'd1);
    tick();
    chk("key T+6 busy", 128'(bsy[1]), 128'd0);
    chk("key retained data", 128'(kod[1]), 128'h7B777C63);

    // Single state request: valid at T+17.
    st_in_data = 128'h0F0E0D0C0B0A09080706050403020100; st_in_valid = 1'b1;
    tick();
    st_in_valid = 1'b0;
    repeat (15) tick();
    chk("st T+16 valid", 128'(sov[1]), 128'd0);
    tick();
    chk("st T+17 valid", 128'(sov[1]), 128'd1);
    chk("st T+17 data", sod[1], 128'h76ABD7FE2B670130C56F6BF27B777C63);
    drain();

    // Simultaneous requests, key pulse only: KP1 serves key then state, KP0 serves state.
    key_in_data = 32'hDEADBEEF; key_in_valid = 1'b1;
    st_in_data = 128'h00112233445566778899AABBCCDDEEFF; st_in_valid = 1'b1;
    tick();
    key_in_valid = 1'b0;
    repeat (4) tick();
    chk("prio1 key first", 128'(kov[1]), 128'd1);
    chk("prio1 key data", 128'(kod[1]), 128'(subword(32'hDEADBEEF)));
    tick();
    chk("prio1 st ready after key", 128'(sir[1]), 128'd1);
    tick();
    st_in_valid = 1'b0;
    repeat (10) tick();
    chk("prio0 st first", 128'(sov[0]), 128'd1);
    repeat (6) tick();
    chk("prio1 st second", 128'(sov[1]), 128'd1);
    drain();

    // Simultaneous requests, state pulse only: KP0 serves state then key at T+18.
    key_in_data = 32'h12345678; key_in_valid = 1'b1;
    st_in_data = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF; st_in_valid = 1'b1;
    tick();
    st_in_valid = 1'b0;
    repeat (16) tick();
    chk("prio0 st at T+17", 128'(sov[0]), 128'd1);
    tick();
    chk("prio0 key ready T+18", 128'(kir[0]), 128'd1);
    tick();
    key_in_valid = 1'b0;
    repeat (4) tick();
    chk("prio0 key at T+23", 128'(kov[0]), 128'd1);
    chk("prio0 key data", 128'(kod[0]), 128'(subword(32'h12345678)));
    drain();

    // Backpressure on the state result for 5 cycles, with both requests pending.
    pat = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    st_out_ready = 1'b0;
    st_in_data = pat; st_in_valid = 1'b1;
    tick();
    st_in_valid = 1'b0;
    repeat (16) tick();
    key_in_data = 32'hFFFFFFFF; key_in_valid = 1'b1; st_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall valid", 128'(sov[1]), 128'd1);
      chk("stall data", sod[0], subbytes(pat));
      chk("stall key ready", 128'(kir[0]), 128'd0);
      chk("stall st ready", 128'(sir[1]), 128'd0);
      tick();
    end
    st_out_ready = 1'b1; st_in_valid = 1'b0;
    tick();
    chk("after handshake busy", 128'(bsy[1]), 128'd0);
    chk("after handshake valid", 128'(sov[1]), 128'd0);
    tick();
    key_in_valid = 1'b0;
    drain();

    // Reset in the middle of a state operation.
    st_in_data = pat ^ 128'h1; st_in_valid = 1'b1;
    tick();
    st_in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid-run reset busy", 128'(bsy[1]), 128'd0);
    chk("mid-run reset st data", sod[1], 128'd0);
    chk("mid-run reset key data", 128'(kod[0]), 128'd0);
    key_in_data = 32'hFFFFFFFF; key_in_valid = 1'b1;
    tick();
    key_in_valid = 1'b0;
    repeat (4) tick();
    chk("post-reset key valid", 128'(kov[1]), 128'd1);
    chk("post-reset key data", 128'(kod[1]), 128'h16161616);
    drain();

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
